// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer: LFSR challenge driver and response packer for an arbiter PUF; `PUF_MAJORITY_VOTE_EN enables VOTES-way majority voting
module puf_challenge_sequencer #(
  parameter int N = 128,
  parameter int W = 32,
  parameter int SETTLE = 4,
  parameter logic [N-1:0] TAPS = N'(128'hA000_0014_0000_0000_0000_0000_0000_0000),
  parameter int VOTES = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         seed_load,
  input  logic [N-1:0] seed,
  input  logic         start,
  input  logic [7:0]   num_words,
  output logic         puf_rst,
  output logic         puf_in,
  output logic [N-1:0] puf_sel,
  input  logic         puf_out,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_word,
  output logic         busy,
  output logic         done
);
  localparam int BW = $clog2(W);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
  localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE - 1);
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_LAUNCH, S_SAMPLE, S_PACK, S_OUT} state_t;
  state_t r_state;
  logic [N-1:0] r_lfsr;
  logic [W-1:0] r_word;
  logic [BW-1:0] r_bits;
  logic [SW-1:0] r_settle;
  logic [7:0] r_sent, r_total;
  logic r_rst, r_in, r_valid, r_done;
  logic [N-1:0] w_seed, w_lfsr_nxt;
  logic w_bit, w_last_vote;
`ifdef PUF_MAJORITY_VOTE_EN
  logic [3:0] r_ones, r_votes;
  assign w_bit = r_ones > 4'(VOTES / 2);
  assign w_last_vote = r_votes == 4'(VOTES - 1);
`else
  logic r_bit;
  assign w_bit = r_bit;
  assign w_last_vote = 1'b1;
`endif
  assign w_seed = seed == '0 ? N'(1) : seed;
  assign w_lfsr_nxt = {r_lfsr[N-2:0], ^(r_lfsr & TAPS)};
  assign puf_rst = r_rst;
  assign puf_in = r_in;
  assign puf_sel = r_lfsr;
  assign resp_valid = r_valid;
  assign resp_word = r_word;
  assign busy = r_state != S_IDLE;
  assign done = r_done;
  // puf_in stays high through SAMPLE so the arbiter output is still held when captured
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lfsr <= N'(1);
      r_word <= '0;
      r_bits <= '0;
      r_settle <= '0;
      r_sent <= '0;
      r_total <= '0;
      r_rst <= 1'b1;
      r_in <= 1'b0;
      r_valid <= 1'b0;
      r_done <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      r_ones <= '0;
      r_votes <= '0;
`else
      r_bit <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (seed_load) r_lfsr <= w_seed;
          if (start) begin
            r_state <= S_ARM;
            r_total <= num_words == '0 ? 8'd1 : num_words;
            r_sent <= '0;
            r_bits <= '0;
            r_word <= '0;
          end
        end
        S_ARM: begin
          r_state <= S_LAUNCH;
          r_rst <= 1'b0;
          r_in <= 1'b1;
          r_settle <= '0;
        end
        S_LAUNCH: begin
          r_settle <= r_settle + 1'b1;
          if (r_settle == LAST_SETTLE) r_state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          r_rst <= 1'b1;
          r_in <= 1'b0;
          r_state <= w_last_vote ? S_PACK : S_ARM;
`ifdef PUF_MAJORITY_VOTE_EN
          r_ones <= r_ones + 4'(puf_out);
          r_votes <= r_votes + 1'b1;
`else
          r_bit <= puf_out;
`endif
        end
        S_PACK: begin
          r_word <= {r_word[W-2:0], w_bit};
          r_lfsr <= w_lfsr_nxt;
          r_bits <= r_bits == LAST_BIT ? '0 : r_bits + 1'b1;
          r_state <= r_bits == LAST_BIT ? S_OUT : S_ARM;
          if (r_bits == LAST_BIT) begin
            r_valid <= 1'b1;
            r_sent <= r_sent + 1'b1;
          end
`ifdef PUF_MAJORITY_VOTE_EN
          r_ones <= '0;
          r_votes <= '0;
`endif
        end
        S_OUT: begin
          if (resp_ready) begin
            r_valid <= 1'b0;
            r_state <= r_sent == r_total ? S_IDLE : S_ARM;
            r_done <= r_sent == r_total;
            if (r_sent != r_total) r_word <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb_puf_challenge_sequencer: scoreboard bench driving a behavioural arbiter PUF model
module tb_puf_challenge_sequencer;
  localparam int N = 128;
  localparam int W = 32;
  localparam int SETTLE = 4;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int V = 5;
`else
  localparam int V = 1;
`endif
  localparam logic [127:0] TAPS = 128'hA000_0014_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] MASK = {16{8'hF0}};
  localparam int LAT = W * (V * (SETTLE + 2) + 1);
  logic clk, reset, seed_load, start, puf_rst, puf_in, puf_out;
  logic resp_valid, resp_ready, busy, done;
  logic [N-1:0] seed, puf_sel;
  logic [7:0] num_words;
  logic [W-1:0] resp_word, e;
  logic [W-1:0] exp_q[$];
  logic [127:0] g_lfsr;
  int n_chk = 0, n_fail = 0, n_done = 0;
  int hi, nl, idx;
  logic pin_d, flip;

  puf_challenge_sequencer #(.N(N), .W(W), .SETTLE(SETTLE), .TAPS(TAPS), .VOTES(5)) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed), .start(start),
    .num_words(num_words), .puf_rst(puf_rst), .puf_in(puf_in), .puf_sel(puf_sel),
    .puf_out(puf_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_word(resp_word), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] nxt(input logic [127:0] s);
    return {s[126:0], ^(s & TAPS)};
  endfunction
  function automatic logic model(input logic [127:0] s);
    return ^(s & MASK);
  endfunction

  // PUF model: response valid SETTLE-1 cycles after launch; votes 1 and 3 of each 5 are flipped
  always @(posedge clk or posedge reset)
    if (reset) begin
      hi <= 0;
      nl <= 0;
      pin_d <= 1'b0;
    end else begin
      hi <= puf_in ? hi + 1 : 0;
      pin_d <= puf_in;
      if (puf_in && !pin_d) nl <= nl + 1;
    end
  assign idx = (nl + 4) % 5;
  assign flip = (V > 1) && (idx == 1 || idx == 3);
  assign puf_out = (puf_in && hi >= SETTLE - 1) ? model(puf_sel) ^ flip : 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) n_done++;
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", resp_word, 'x);
      else begin
        e = exp_q.pop_front();
        chk("resp_word", resp_word, e);
      end
    end
  end

  task automatic run(input bit ld, input logic [127:0] sd, input logic [7:0] nw, input bit stall, input bit poke);
    int k, cyc, d0;
    logic [W-1:0] w, w0;
    logic [127:0] first;
    bit bad;
    if (ld) g_lfsr = (sd == '0) ? 128'h1 : sd;
    first = g_lfsr;
    k = (nw == 0) ? 1 : int'(nw);
    for (int i = 0; i < k; i++) begin
      w = '0;
      for (int b = 0; b < W; b++) begin
        w = {w[W-2:0], model(g_lfsr)};
        g_lfsr = nxt(g_lfsr);
      end
      exp_q.push_back(w);
    end
    d0 = n_done;
    resp_ready = !stall;
    @(negedge clk);
    seed_load = ld; seed = sd; start = 1'b1; num_words = nw;
    @(posedge clk);
    #1 seed_load = 1'b0; start = 1'b0; num_words = 8'd9;
    chk("first_sel", puf_sel, first);
    for (int i = 0; i < k; i++) begin
      cyc = 0;
      while (!resp_valid && cyc < 4000) begin
        @(posedge clk);
        #1 cyc++;
        if (poke && i == 0 && cyc == 40) begin
          start = 1'b1; seed_load = 1'b1; seed = 128'hDEAD_BEEF;
          @(posedge clk);
          #1 start = 1'b0; seed_load = 1'b0; cyc++;
        end
      end
      if (!resp_valid) begin
        n_chk++; n_fail++;
        $display("FAIL valid_timeout: no resp_valid within %0d cycles", cyc);
        return;
      end
      if (i == 0) chk("latency", cyc, LAT);
      if (stall) begin
        w0 = resp_word;
        bad = 1'b0;
        repeat (50) begin
          @(posedge clk);
          #1 if (resp_word !== w0 || puf_in !== 1'b0 || puf_rst !== 1'b1 || resp_valid !== 1'b1) bad = 1'b1;
        end
        chk("stall_stable", bad, 0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    chk("idle_after_run", busy, 0);
    repeat (2) @(negedge clk);
    chk("done_pulses", n_done - d0, 1);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; seed_load = 1'b0; seed = '0; num_words = '0; resp_ready = 1'b1;
    g_lfsr = 128'h1;
    @(negedge clk);
    chk("rst_puf_rst", puf_rst, 1);
    chk("rst_puf_in", puf_in, 0);
    chk("rst_puf_sel", puf_sel, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_word", resp_word, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    // reset in the middle of LAUNCH
    @(negedge clk);
    seed_load = 1'b1; seed = 128'hA5; start = 1'b1; num_words = 8'd1;
    @(posedge clk);
    #1 seed_load = 1'b0; start = 1'b0;
    chk("t1_seeded_sel", puf_sel, 128'hA5);
    cyc = 0;
    while (!puf_in && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("t1_launch_seen", puf_in, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("t1_busy", busy, 0);
    chk("t1_puf_rst", puf_rst, 1);
    chk("t1_puf_in", puf_in, 0);
    chk("t1_valid", resp_valid, 0);
    chk("t1_puf_sel", puf_sel, 1);
    reset = 1'b0;
    g_lfsr = 128'h1;
    run(1'b1, 128'h0, 8'd1, 1'b0, 1'b0);
    run(1'b1, 128'hA5, 8'd3, 1'b1, 1'b0);
    run(1'b0, 128'h0, 8'd2, 1'b0, 1'b1);
    run(1'b0, 128'h0, 8'd0, 1'b0, 1'b0);
    run(1'b0, 128'h0, 8'd1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
